// File: rtl/encoder_pkg.sv
// Shared widths, reset values and helpers for the 8-to-3 priority encoder.
// The index mask helper lets the core build each y bit as an OR of winners.
package encoder_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  localparam logic [OUT_W-1:0] Y_RST     = '0;
  localparam logic             VALID_RST = 1'b0;
  localparam logic             MULTI_RST = 1'b0;

  typedef struct packed {
    logic [OUT_W-1:0] y;
    logic             valid;
    logic             multi;
  } enc_out_t;

  localparam enc_out_t ENC_RST = '{y: Y_RST, valid: VALID_RST, multi: MULTI_RST};

  // Bit i of the mask is set when bit b of the index i is set.
  function automatic logic [IN_W-1:0] idx_mask(input int b);
    logic [IN_W-1:0] m;
    m = '0;
    for (int i = 0; i < IN_W; i++) begin
      m[i] = i[b];
    end
    return m;
  endfunction

endpackage

// File: rtl/encoder_8to3_core.sv
// Combinational priority encode of d: one-hot winner select, index OR-tree,
// and a direction-independent multi-hot flag.
module encoder_8to3_core
  import encoder_pkg::*;
#(
  parameter bit MSB_PRIORITY = 1'b1
) (
  input  logic [IN_W-1:0]  d,
  input  logic             enable,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi
);

  logic [IN_W-1:0]  win;
  logic [OUT_W-1:0] y_raw;

  // The last matching bit scanned wins, so scan order sets the priority.
  always_comb begin
    win = '0;
    if (MSB_PRIORITY) begin
      for (int i = 0; i < IN_W; i++) begin
        if (d[i]) win = IN_W'(1) << i;
      end
    end else begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (d[i]) win = IN_W'(1) << i;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_y
      assign y_raw[gi] = |(win & idx_mask(gi));
    end
  endgenerate

  always_comb begin
    y     = Y_RST;
    valid = VALID_RST;
    multi = MULTI_RST;
    if (enable) begin
      y     = y_raw;
      valid = |d;
      multi = |(d & (d - IN_W'(1)));
    end
  end

endmodule

// File: rtl/encoder_8to3.sv
// 8-to-3 priority encoder top: core encode plus an optional output register
// cleared asynchronously by rst_n.
module encoder_8to3
  import encoder_pkg::*;
#(
  parameter bit MSB_PRIORITY = 1'b1,
  parameter bit REG_OUT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  d,
  input  logic             enable,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi
);

  enc_out_t out_next;
  enc_out_t out_cur;

  encoder_8to3_core #(
    .MSB_PRIORITY(MSB_PRIORITY)
  ) u_core (
    .d      (d),
    .enable (enable),
    .y      (out_next.y),
    .valid  (out_next.valid),
    .multi  (out_next.multi)
  );

  generate
    if (REG_OUT) begin : g_reg
      enc_out_t out_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_reg <= ENC_RST;
        end else begin
          out_reg <= out_next;
        end
      end

      assign out_cur = out_reg;
    end else begin : g_comb
      // Reset still forces the idle value even without a register.
      assign out_cur = rst_n ? out_next : ENC_RST;
    end
  endgenerate

  assign y     = out_cur.y;
  assign valid = out_cur.valid;
  assign multi = out_cur.multi;

endmodule

// File: tb/tb_encoder_8to3.sv
// Bench for encoder_8to3: four parameter variants driven in lockstep and
// compared against an arithmetic reference model.
module tb_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       enable;

  logic [2:0] y_rm, y_rl, y_cm, y_cl;
  logic       v_rm, v_rl, v_cm, v_cl;
  logic       m_rm, m_rl, m_cm, m_cl;

  int tests;
  int fails;

  logic [4:0] exp_rm, exp_rl;

  encoder_8to3 #(.MSB_PRIORITY(1'b1), .REG_OUT(1'b1)) u_rm (
    .clk(clk), .rst_n(rst_n), .d(d), .enable(enable), .y(y_rm), .valid(v_rm), .multi(m_rm));
  encoder_8to3 #(.MSB_PRIORITY(1'b0), .REG_OUT(1'b1)) u_rl (
    .clk(clk), .rst_n(rst_n), .d(d), .enable(enable), .y(y_rl), .valid(v_rl), .multi(m_rl));
  encoder_8to3 #(.MSB_PRIORITY(1'b1), .REG_OUT(1'b0)) u_cm (
    .clk(clk), .rst_n(rst_n), .d(d), .enable(enable), .y(y_cm), .valid(v_cm), .multi(m_cm));
  encoder_8to3 #(.MSB_PRIORITY(1'b0), .REG_OUT(1'b0)) u_cl (
    .clk(clk), .rst_n(rst_n), .d(d), .enable(enable), .y(y_cl), .valid(v_cl), .multi(m_cl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {y, valid, multi}; index from log2 arithmetic on the request value.
  function automatic logic [4:0] ref_enc(input logic [7:0] dv, input logic ev, input bit msb);
    int         idx;
    logic [7:0] low;
    logic [2:0] yi;
    if (!ev || dv == 8'h00) return 5'b0;
    low = dv & (~dv + 8'd1);
    idx = msb ? ($clog2(int'(dv) + 1) - 1) : $clog2(int'(low));
    yi  = 3'(idx);
    return {yi, 1'b1, ($countones(dv) > 1)};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s d=%02h en=%0b observed y/v/m=%0d/%0b/%0b required y/v/m=%0d/%0b/%0b",
             tag, d, enable, obs[4:2], obs[1], obs[0], expv[4:2], expv[1], expv[0]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rm"}, {y_rm, v_rm, m_rm}, 5'b0);
    check({tag, "_rl"}, {y_rl, v_rl, m_rl}, 5'b0);
    check({tag, "_cm"}, {y_cm, v_cm, m_cm}, 5'b0);
    check({tag, "_cl"}, {y_cl, v_cl, m_cl}, 5'b0);
  endtask

  // Called just after a falling edge: inputs change mid-cycle.
  task automatic step(input string tag, input logic [7:0] dv, input logic ev);
    d      = dv;
    enable = ev;
    #1;
    check({tag, "_comb_msb"}, {y_cm, v_cm, m_cm}, ref_enc(dv, ev, 1'b1));
    check({tag, "_comb_lsb"}, {y_cl, v_cl, m_cl}, ref_enc(dv, ev, 1'b0));
    check({tag, "_hold_msb"}, {y_rm, v_rm, m_rm}, exp_rm);
    check({tag, "_hold_lsb"}, {y_rl, v_rl, m_rl}, exp_rl);
    @(posedge clk);
    #1;
    exp_rm = ref_enc(dv, ev, 1'b1);
    exp_rl = ref_enc(dv, ev, 1'b0);
    check({tag, "_reg_msb"}, {y_rm, v_rm, m_rm}, exp_rm);
    check({tag, "_reg_lsb"}, {y_rl, v_rl, m_rl}, exp_rl);
    $display("[TB] %s d=%02h en=%0b y_msb=%0d y_lsb=%0d", tag, dv, ev, y_rm, y_rl);
    @(negedge clk);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    exp_rm = 5'b0;
    exp_rl = 5'b0;
    rst_n  = 1'b0;
    d      = 8'hFF;
    enable = 1'b1;
    #1;
    check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;

    // First edge after release loads the encode present at that edge.
    step("post_reset", 8'h24, 1'b1);

    for (int i = 0; i < 8; i++) begin
      step("onehot", 8'(1 << i), 1'b1);
    end

    step("zero_dis", 8'h00, 1'b0);
    step("zero_en", 8'h00, 1'b1);
    step("dis_10", 8'h10, 1'b0);
    step("multi_ff", 8'hFF, 1'b1);
    step("multi_24", 8'b0010_0100, 1'b1);

    step("lat_01", 8'h01, 1'b1);
    step("lat_08", 8'h08, 1'b1);

    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    step("pre_rst", 8'h80, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_rm = 5'b0;
    exp_rl = 5'b0;
    d      = 8'h81;
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst", 8'h06, 1'b1);

    for (int e = 0; e < 2; e++) begin
      for (int v = 0; v < 256; v++) begin
        step("exh", 8'(v), 1'(e));
      end
    end

    for (int k = 0; k < 200; k++) begin
      step("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
